// File: rtl/utm_run_controller_pkg.sv
// Shared types and constants for the Turing-machine run controller.
package utm_run_controller_pkg;

  localparam int unsigned SymW = 3;
  localparam logic [SymW-1:0] HaltStateDefault = 3'd7;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } run_state_e;

endpackage

// File: rtl/utm_tape_mem.sv
// Tape storage: DEPTH x 3-bit cells, one write port, head and debug read ports.
module utm_tape_mem
  import utm_run_controller_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SymW-1:0]   wdata,
  input  logic [ADDR_W-1:0] head_addr,
  output logic [SymW-1:0]   head_sym,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [SymW-1:0]   dbg_sym
);

  logic [SymW-1:0] cells_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells_q[i] <= '0;
      end
    end else if (we) begin
      cells_q[waddr] <= wdata;
    end
  end

  assign head_sym = cells_q[head_addr];
  assign dbg_sym  = cells_q[dbg_addr];

endmodule

// File: rtl/utm_run_controller.sv
// Sequencer for a Turing-machine transition function: owns tape, head, state and step count.
module utm_run_controller
  import utm_run_controller_pkg::*;
#(
  parameter int unsigned     DEPTH       = 16,
  parameter int unsigned     ADDR_W      = 4,
  parameter int unsigned     HEAD_INIT   = 0,
  parameter logic [SymW-1:0] START_STATE = '0,
  parameter logic [SymW-1:0] HALT_STATE  = HaltStateDefault,
  parameter int unsigned     MAX_STEPS   = 255,
  parameter int unsigned     CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [SymW-1:0]   load_sym,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  output logic [SymW-1:0]   tf_state,
  output logic [SymW-1:0]   tf_sym,
  input  logic [SymW-1:0]   tf_next_state,
  input  logic [SymW-1:0]   tf_new_sym,
  input  logic              tf_move_right,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SymW-1:0]   rd_sym,
  output logic [ADDR_W-1:0] head_pos,
  output logic [CNT_W-1:0]  step_count,
  output logic              busy,
  output logic              halted,
  output logic              edge_fault,
  output logic              timeout
);

  localparam logic [ADDR_W-1:0] HeadInit = ADDR_W'(HEAD_INIT);
  localparam logic [ADDR_W-1:0] HeadLast = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  MaxSteps = CNT_W'(MAX_STEPS);

  run_state_e        fsm_q, fsm_d;
  logic [SymW-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              edge_fault_q, edge_fault_d;
  logic              timeout_q, timeout_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [SymW-1:0]   wdata;
  logic              en;
  logic              at_edge;

  assign en      = !step_mode || step;
  assign at_edge = (head_q == '0 && !tf_move_right) || (head_q == HeadLast && tf_move_right);

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    head_d       = head_q;
    cnt_d        = cnt_q;
    edge_fault_d = edge_fault_q;
    timeout_d    = timeout_q;
    we           = 1'b0;
    waddr        = head_q;
    wdata        = tf_new_sym;

    unique case (fsm_q)
      StIdle: begin
        if (load_en) begin
          we    = 1'b1;
          waddr = load_addr;
          wdata = load_sym;
        end
        if (start) begin
          fsm_d        = StRun;
          state_d      = START_STATE;
          head_d       = HeadInit;
          cnt_d        = '0;
          edge_fault_d = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      StRun: begin
        if (abort) begin
          fsm_d = StIdle;
        end else if (en) begin
          if (state_q == HALT_STATE) begin
            fsm_d = StHalted;
          end else if (cnt_q == MaxSteps) begin
            fsm_d     = StHalted;
            timeout_d = 1'b1;
          end else begin
            we      = 1'b1;
            state_d = tf_next_state;
            cnt_d   = cnt_q + 1'b1;
            // An off-tape move still commits the write, but the head stays put.
            if (at_edge) begin
              edge_fault_d = 1'b1;
              fsm_d        = StHalted;
            end else begin
              head_d = tf_move_right ? head_q + 1'b1 : head_q - 1'b1;
            end
          end
        end
      end
      StHalted: begin
        if (abort) begin
          fsm_d = StIdle;
        end else if (start) begin
          fsm_d        = StRun;
          state_d      = START_STATE;
          head_d       = HeadInit;
          cnt_d        = '0;
          edge_fault_d = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= StIdle;
      state_q      <= START_STATE;
      head_q       <= HeadInit;
      cnt_q        <= '0;
      edge_fault_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      head_q       <= head_d;
      cnt_q        <= cnt_d;
      edge_fault_q <= edge_fault_d;
      timeout_q    <= timeout_d;
    end
  end

  utm_tape_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_tape (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .head_addr(head_q),
    .head_sym (tf_sym),
    .dbg_addr (rd_addr),
    .dbg_sym  (rd_sym)
  );

  assign tf_state   = state_q;
  assign head_pos   = head_q;
  assign step_count = cnt_q;
  assign busy       = (fsm_q == StRun);
  assign halted     = (fsm_q == StHalted);
  assign edge_fault = edge_fault_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_utm_run_controller.sv
// Directed and randomized checks of utm_run_controller against a Turing-machine reference model.
module tb_utm_run_controller;

  localparam int Depth    = 16;
  localparam int MaxSteps = 10;
  localparam int HaltSt   = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [2:0] load_sym = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [2:0] tf_state, tf_sym, tf_next_state, tf_new_sym;
  logic       tf_move_right;
  logic [3:0] rd_addr = '0;
  logic [2:0] rd_sym;
  logic [3:0] head_pos;
  logic [7:0] step_count;
  logic       busy, halted, edge_fault, timeout;

  // Transition function entry: {next_state, new_sym, move_right}, indexed by {state, sym}.
  logic [6:0] tf_table [64];
  assign {tf_next_state, tf_new_sym, tf_move_right} = tf_table[{tf_state, tf_sym}];

  int checks = 0;
  int failures = 0;

  int m_tape [Depth];
  int m_head, m_state, m_steps, m_cycles;
  bit m_edge, m_tmo;

  utm_run_controller #(
    .DEPTH      (16),
    .ADDR_W     (4),
    .HEAD_INIT  (0),
    .START_STATE(3'd0),
    .HALT_STATE (3'd7),
    .MAX_STEPS  (MaxSteps),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_sym     (load_sym),
    .start        (start),
    .abort        (abort),
    .step_mode    (step_mode),
    .step         (step),
    .tf_state     (tf_state),
    .tf_sym       (tf_sym),
    .tf_next_state(tf_next_state),
    .tf_new_sym   (tf_new_sym),
    .tf_move_right(tf_move_right),
    .rd_addr      (rd_addr),
    .rd_sym       (rd_sym),
    .head_pos     (head_pos),
    .step_count   (step_count),
    .busy         (busy),
    .halted       (halted),
    .edge_fault   (edge_fault),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tape_chk(input int addr, input int exp, input string tag);
    rd_addr = 4'(addr);
    #1;
    chk(tag, 32'(rd_sym), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  // Plain Turing-machine interpretation of the run rules on the model tape.
  task automatic model_run();
    int ent;
    m_head = 0; m_state = 0; m_steps = 0; m_edge = 0; m_tmo = 0;
    forever begin
      if (m_state == HaltSt) begin m_cycles = m_steps + 1; break; end
      if (m_steps == MaxSteps) begin m_tmo = 1; m_cycles = m_steps + 1; break; end
      ent = int'(tf_table[m_state * 8 + m_tape[m_head]]);
      m_tape[m_head] = (ent >> 1) & 7;
      m_state = (ent >> 4) & 7;
      m_steps++;
      if ((ent & 1) == 1) begin
        if (m_head == Depth - 1) begin m_edge = 1; m_cycles = m_steps; break; end
        m_head++;
      end else begin
        if (m_head == 0) begin m_edge = 1; m_cycles = m_steps; break; end
        m_head--;
      end
    end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) tf_table[i] = '0;
    #12 rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_edge", 32'(edge_fault), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_cnt", 32'(step_count), 0);
    chk("rst_head", 32'(head_pos), 0);
    chk("rst_state", 32'(tf_state), 0);
    tape_chk(5, 0, "rst_tape5");

    // Preload and read back
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_sym = 3'(i + 1);
      tick();
    end
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) tape_chk(i, i + 1, "preload");

    // Write 5, move right, next = state+1; free-run with load_en held during the run
    for (int s = 0; s < 8; s++)
      for (int y = 0; y < 8; y++) tf_table[s * 8 + y] = {3'(s + 1), 3'd5, 1'b1};
    pulse_start();
    chk("run_busy", 32'(busy), 1);
    load_en = 1'b1; load_addr = 4'd10; load_sym = 3'd6;
    wait_halt(20, cyc);
    chk("run_halt_latency", 32'(cyc), 8);
    chk("run_cnt", 32'(step_count), 7);
    chk("run_head", 32'(head_pos), 7);
    chk("run_state", 32'(tf_state), 7);
    repeat (3) tick();
    load_en = 1'b0;
    chk("halt_frozen_cnt", 32'(step_count), 7);
    for (int i = 0; i < 7; i++) tape_chk(i, 5, "run_tape");
    tape_chk(7, 0, "run_tape7");
    tape_chk(10, 0, "load_ignored");

    // Single-step mode: pulses every 4 cycles
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", 32'(halted), 0);
    step_mode = 1'b1;
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      repeat (3) begin
        tick();
        chk("step_hold", 32'(step_count), 32'(p));
      end
      step = 1'b1; tick(); step = 1'b0;
    end
    chk("step_cnt", 32'(step_count), 3);
    chk("step_head", 32'(head_pos), 3);
    chk("step_busy", 32'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    step_mode = 1'b0;
    chk("step_abort", 32'(busy), 0);

    // Always move left from head 0: one commit then edge fault
    for (int i = 0; i < 64; i++) tf_table[i] = {3'd0, 3'd6, 1'b0};
    pulse_start();
    wait_halt(5, cyc);
    chk("left_latency", 32'(cyc), 1);
    chk("left_cnt", 32'(step_count), 1);
    chk("left_edge", 32'(edge_fault), 1);
    chk("left_head", 32'(head_pos), 0);
    chk("left_tmo", 32'(timeout), 0);
    tape_chk(0, 6, "left_tape0");
    tape_chk(1, 5, "left_tape1");

    // Self-loop on state 0 until the step limit
    for (int i = 0; i < 64; i++) tf_table[i] = {3'd0, 3'd2, 1'b1};
    abort = 1'b1; tick(); abort = 1'b0;
    pulse_start();
    chk("restart_clears_edge", 32'(edge_fault), 0);
    wait_halt(30, cyc);
    chk("tmo_latency", 32'(cyc), 11);
    chk("tmo_flag", 32'(timeout), 1);
    chk("tmo_cnt", 32'(step_count), 10);
    chk("tmo_head", 32'(head_pos), 10);

    // Abort two cycles into a run
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_keeps_flag", 32'(timeout), 1);
    for (int s = 0; s < 8; s++)
      for (int y = 0; y < 8; y++) tf_table[s * 8 + y] = {3'(s + 1), 3'd3, 1'b1};
    pulse_start();
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(step_count), 2);
    tape_chk(0, 3, "abort_tape0");
    tape_chk(1, 3, "abort_tape1");
    tape_chk(2, 2, "abort_tape2");
    step_mode = 1'b1;
    pulse_start();
    chk("restart_cnt", 32'(step_count), 0);
    chk("restart_tmo", 32'(timeout), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    step_mode = 1'b0;

    // Randomized machines against the reference model
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 64; i++) tf_table[i] = 7'($urandom);
      for (int i = 0; i < Depth; i++) begin
        m_tape[i] = int'($urandom_range(0, 7));
        load_en = 1'b1; load_addr = 4'(i); load_sym = 3'(m_tape[i]);
        tick();
      end
      load_en = 1'b0;
      model_run();
      step_mode = (it % 2 == 1);
      pulse_start();
      cyc = 0;
      while (!halted && cyc < 200) begin
        step = step_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        cyc++;
      end
      step = 1'b0;
      chk("rnd_halted", 32'(halted), 1);
      if (!step_mode) chk("rnd_latency", 32'(cyc), 32'(m_cycles));
      chk("rnd_cnt", 32'(step_count), 32'(m_steps));
      chk("rnd_head", 32'(head_pos), 32'(m_head));
      chk("rnd_state", 32'(tf_state), 32'(m_state));
      chk("rnd_edge", 32'(edge_fault), 32'(m_edge));
      chk("rnd_tmo", 32'(timeout), 32'(m_tmo));
      for (int i = 0; i < Depth; i++) tape_chk(i, m_tape[i], "rnd_tape");
      abort = 1'b1; tick(); abort = 1'b0;
      step_mode = 1'b0;
    end

    // Reset asserted mid-run
    for (int i = 0; i < 64; i++) tf_table[i] = {3'd1, 3'd4, 1'b1};
    pulse_start();
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(step_count), 0);
    chk("mid_rst_head", 32'(head_pos), 0);
    chk("mid_rst_state", 32'(tf_state), 0);
    chk("mid_rst_tfsym", 32'(tf_sym), 0);
    for (int i = 0; i < 4; i++) tape_chk(i, 0, "mid_rst_tape");
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
